network_if_arbiter: RTL and testbench

Many-to-one merge stage for the network datapath. It takes NUM_IN independent network_if producer streams (val/id/valid/ready), picks one accepted transfer per cycle with a fair round-robin arbiter, and presents the merged stream on a single network_if master port through a registered FIFO. It also tags each beat with the index of the input it came from. It sits where per-lane node outputs converge onto a shared link, in the opposite direction to the one-to-one stream copy/register stages.

---
 rtl/network_if_arbiter.sv | 67 ++++++
 tb/tb_network_if_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/network_if_arbiter.sv
// network_if_arbiter: round-robin many-to-one stream merge into a registered FIFO tagged with source lane
module network_if_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int IN_WIDTH   = 32,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int SRC_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*IN_WIDTH-1:0]   in_val,
  input  logic [NUM_IN*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [IN_WIDTH-1:0]          out_val,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic [SRC_WIDTH-1:0]         out_src,
  output logic                         out_valid,
  input  logic                         out_ready
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = ID_WIDTH + IN_WIDTH + SRC_WIDTH;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [SRC_WIDTH-1:0] ptr, g;
  logic                 found, space, push, pop;
  int                   idx;
  // search lanes starting at ptr with modular wrap; first valid lane wins
  always_comb begin
    g = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (!found && in_valid[idx]) begin
        g = SRC_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end
  assign space     = count < CW'(FIFO_DEPTH);
  assign push      = rst_n && found && space;
  assign in_ready  = push ? ({{(NUM_IN-1){1'b0}}, 1'b1} << g) : '0;
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign {out_id, out_val, out_src} = mem[rd_ptr];
  // FIFO storage, pointers, occupancy and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ptr    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_id[g*ID_WIDTH +: ID_WIDTH], in_val[g*IN_WIDTH +: IN_WIDTH], g};
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        ptr         <= (g == SRC_WIDTH'(NUM_IN-1)) ? '0 : g + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_network_if_arbiter.sv
// tb_network_if_arbiter: directed and random checks of the merge arbiter against a queue-based model
module tb_network_if_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_val;
  logic [31:0]  in_id;
  logic [3:0]   in_valid, in_ready;
  logic [31:0]  out_val;
  logic [7:0]   out_id;
  logic [1:0]   out_src;
  logic         out_valid, out_ready;
  logic [95:0]  in_val3;
  logic [23:0]  in_id3;
  logic [2:0]   in_valid3, in_ready3;
  logic [31:0]  out_val3;
  logic [7:0]   out_id3;
  logic [1:0]   out_src3;
  logic         out_valid3, out_ready3;
  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] v; logic [7:0] id; int src;} beat_t;
  beat_t q[$];
  int mptr = 0;

  always #5 clk = ~clk;

  network_if_arbiter dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_id(in_id), .in_valid(in_valid),
    .in_ready(in_ready), .out_val(out_val), .out_id(out_id), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready));

  network_if_arbiter #(.NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val3), .in_id(in_id3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_val(out_val3), .out_id(out_id3), .out_src(out_src3),
    .out_valid(out_valid3), .out_ready(out_ready3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rnd_data();
    for (int i = 0; i < 4; i++) begin
      in_val[i*32 +: 32] = $urandom;
      in_id[i*8 +: 8]    = 8'($urandom);
    end
  endtask

  // one clock: check DUT against the model mid-cycle, then advance the model at the edge
  task automatic cyc();
    int gl;
    logic [3:0] exp_rdy;
    bit pop;
    beat_t b;
    @(negedge clk);
    gl = -1;
    for (int k = 0; k < 4; k++)
      if (gl < 0 && in_valid[(mptr + k) % 4]) gl = (mptr + k) % 4;
    exp_rdy = '0;
    if (gl >= 0 && q.size() < 2) exp_rdy[gl] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_val", 64'(out_val), 64'(q[0].v));
      chk("out_id", 64'(out_id), 64'(q[0].id));
      chk("out_src", 64'(out_src), 64'(q[0].src));
    end
    pop = q.size() != 0 && out_ready;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (exp_rdy != 0) begin
      b.v = in_val[gl*32 +: 32];
      b.id = in_id[gl*8 +: 8];
      b.src = gl;
      q.push_back(b);
      mptr = (gl + 1) % 4;
    end
    #1;
  endtask

  task automatic drain();
    in_valid = '0;
    out_ready = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    in_val = '0; in_id = '0; in_valid = 4'hF; out_ready = 1'b0;
    in_val3 = '0; in_id3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    #12;
    chk("reset in_ready", 64'(in_ready), 64'h0);
    chk("reset out_valid", 64'(out_valid), 64'h0);
    chk("reset out_val", 64'(out_val), 64'h0);
    chk("reset out_src", 64'(out_src), 64'h0);
    in_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // fairness sweep, all lanes valid, no backpressure
    in_valid = 4'hF; out_ready = 1'b1;
    repeat (12) begin rnd_data(); cyc(); end
    drain();
    // sparse lanes with ptr moved to 2
    in_valid = 4'b0010; rnd_data(); cyc();
    in_valid = 4'b1010;
    repeat (4) begin rnd_data(); cyc(); end
    drain();
    // full and backpressure on lane 2
    out_ready = 1'b0; in_valid = 4'b0100;
    in_val[64 +: 32] = 32'hA5; in_id[16 +: 8] = 8'h11; cyc();
    in_val[64 +: 32] = 32'h5A; in_id[16 +: 8] = 8'h22; cyc();
    cyc();
    chk("full in_ready", 64'(in_ready), 64'h0);
    chk("hold out_val", 64'(out_val), 64'hA5);
    chk("hold out_id", 64'(out_id), 64'h11);
    chk("hold out_src", 64'(out_src), 64'h2);
    out_ready = 1'b1;
    in_val[64 +: 32] = 32'h77; in_id[16 +: 8] = 8'h33;
    repeat (4) cyc();
    // refill two entries then assert reset between edges
    out_ready = 1'b0; in_valid = 4'hF;
    rnd_data(); cyc(); rnd_data(); cyc();
    chk("two buffered", 64'(out_valid), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'h0);
    chk("async reset in_ready", 64'(in_ready), 64'h0);
    chk("async reset out_val", 64'(out_val), 64'h0);
    q.delete();
    mptr = 0;
    rst_n = 1'b1;
    in_valid = 4'b0011; out_ready = 1'b1;
    rnd_data();
    repeat (3) cyc();
    // random regression
    repeat (400) begin
      rnd_data();
      in_valid = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    drain();
    // three-lane instance: wrap after lane 2 back to lane 0
    in_valid3 = 3'b111;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("nin3 in_ready", 64'(in_ready3), 64'(3'b001 << (k % 3)));
      chk("nin3 out_valid", 64'(out_valid3), 64'(k > 0));
      if (k > 0) chk("nin3 out_src", 64'(out_src3), 64'((k - 1) % 3));
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
